// File: rtl/mrelbp_out_buffer.sv
// Output FWFT FIFO with early back-pressure and histogram framing for the MRELBP stream.
// Optional m_axis_tuser[2:0] {first word, hist_idx} is enabled by defining MRELBP_OUT_TUSER_EN.
module mrelbp_out_buffer #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned SKID           = 2,
  parameter int unsigned WORDS_PER_HIST = 200
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic [31:0]              s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [31:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [1:0]               hist_idx_o,
  output logic                     frame_done_o,
  output logic                     overflow_o,
`ifdef MRELBP_OUT_TUSER_EN
  output logic [2:0]               m_axis_tuser,
`endif
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WCW = (WORDS_PER_HIST > 1) ? $clog2(WORDS_PER_HIST) : 1;

  localparam logic [CW-1:0]  FULL    = CW'(DEPTH);
  localparam logic [CW-1:0]  RDY_LIM = CW'(DEPTH - SKID);
  localparam logic [WCW-1:0] WC_LAST = WCW'(WORDS_PER_HIST - 1);

  typedef enum logic [1:0] {
    HIST_R2 = 2'd0,
    HIST_R4 = 2'd1,
    HIST_R6 = 2'd2
  } hist_e;

  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_nxt;
  logic [WCW-1:0] word_cnt;
  hist_e          hist_idx;
  logic           push, pop, drop;

  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = mem[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid & (word_cnt == WC_LAST);
  assign hist_idx_o    = hist_idx;
  assign level_o       = count;

`ifdef MRELBP_OUT_TUSER_EN
  assign m_axis_tuser = m_axis_tvalid ? {(word_cnt == '0), hist_idx} : 3'b000;
`endif

  // s_axis_tready is advisory: a word is taken whenever there is room,
  // including a slot freed by a pop in the same cycle.
  always_comb begin
    pop       = m_axis_tvalid & m_axis_tready;
    push      = s_axis_tvalid & ((count != FULL) | pop);
    drop      = s_axis_tvalid & (count == FULL) & ~pop;
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !clear_i) mem[wr_ptr] <= s_axis_tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      word_cnt      <= '0;
      hist_idx      <= HIST_R2;
      s_axis_tready <= 1'b0;
      frame_done_o  <= 1'b0;
      overflow_o    <= 1'b0;
    end else if (clear_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      word_cnt      <= '0;
      hist_idx      <= HIST_R2;
      // Cleared FIFO is empty, so ready reflects next_count = 0 right away.
      s_axis_tready <= (RDY_LIM != '0);
      frame_done_o  <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count         <= count_nxt;
      s_axis_tready <= (count_nxt < RDY_LIM);
      if (drop) overflow_o <= 1'b1;
      frame_done_o  <= 1'b0;
      if (pop) begin
        if (m_axis_tlast) begin
          word_cnt <= '0;
          case (hist_idx)
            HIST_R2: hist_idx <= HIST_R4;
            HIST_R4: hist_idx <= HIST_R6;
            HIST_R6: begin
              hist_idx     <= HIST_R2;
              frame_done_o <= 1'b1;
            end
            default: hist_idx <= HIST_R2;
          endcase
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mrelbp_out_buffer.md
Name: mrelbp_out_buffer

Overview:
- Downstream output stage for the MRELBP core's 32-bit joint-histogram stream.
- The core's master output is registered one cycle after its internal read enable, so up to SKID words may still arrive after tready drops. This block absorbs those words in a FWFT FIFO with early back-pressure.
- Frames the stream for a DMA: tlast at each histogram boundary (R2, R4, R6), per-word histogram index, end-of-frame pulse, sticky overflow flag.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 4
SKID, 2, free slots reserved for in-flight upstream words
WORDS_PER_HIST, 200, 32-bit words per radius histogram

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
clear_i  input  1  synchronous soft clear, one-cycle or level
s_axis_tdata  input  32  histogram word from core
s_axis_tvalid  input  1  word valid
s_axis_tready  output  1  registered back-pressure to core
m_axis_tdata  output  32  buffered word
m_axis_tvalid  output  1  buffered word valid
m_axis_tready  input  1  sink ready
m_axis_tlast  output  1  last word of current histogram
hist_idx_o  output  2  histogram of current head word: 0=R2, 1=R4, 2=R6
frame_done_o  output  1  one-cycle pulse after last R6 word leaves
overflow_o  output  1  sticky: a word was dropped
level_o  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: pointers, count, word_cnt, hist_idx = 0. s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, frame_done_o = 0, overflow_o = 0, level_o = 0. m_axis_tdata is don't-care while tvalid = 0.
- clear_i has the same effect as reset, applied at the clock edge. It overrides any push or pop in that cycle.
- Push: s_axis_tvalid=1 and (count<DEPTH or pop in the same cycle).
  - s_axis_tready is advisory only. The word is written even when s_axis_tready=0, because the core does not stop instantly.
- Drop: s_axis_tvalid=1, count==DEPTH, no pop in that cycle. The word is discarded and overflow_o is set. overflow_o stays set until reset or clear_i.
- s_axis_tready register: the next value is 1 iff next_count < DEPTH-SKID, so it updates in the same edge as count.
- Read side is FWFT:
  - m_axis_tvalid = (count != 0).
  - m_axis_tdata = mem[rd_ptr], combinational from the array.
  - Pop = m_axis_tvalid & m_axis_tready.
- Latency: a word pushed at edge N is visible on m_axis at edge N with count=1. That is one cycle from s_axis input to m_axis_tvalid.
- Simultaneous push and pop: count is unchanged. This is legal both at full and at 1 entry.
- Pointers wrap modulo DEPTH. count has range 0..DEPTH. level_o = count.
- m_axis_tdata/tvalid/tlast hold stable while tvalid=1 and tready=0 (AXI-Stream rule).
- Framing counters advance on pop only:
  - m_axis_tlast = m_axis_tvalid & (word_cnt == WORDS_PER_HIST-1).
  - Pop without tlast: word_cnt+1.
  - Pop with tlast: word_cnt→0 and hist_idx→hist_idx+1, except hist_idx==2 → 0 with frame_done_o=1 on the following cycle.
  - hist_idx value 3 is unreachable.
- Histogram-to-histogram transitions in the core need no special handling. Words arrive in order R2, R4, R6, and only the count defines boundaries.
- Idle sink (m_axis_tready=0 for a long time): FIFO fills, then s_axis_tready=0, then the core stalls. Up to SKID words arriving after that are still accepted. Loss occurs only beyond DEPTH.

Optional Feature:
MRELBP_OUT_TUSER_EN:
- Defined: adds output port m_axis_tuser[2:0] with the same timing as m_axis_tdata.
  - bits [1:0] = hist_idx.
  - bit 2 = first word of a histogram (word_cnt==0).
  - Reset value 0, forced 0 when m_axis_tvalid=0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
(Bench parameters: DEPTH=8, SKID=2, WORDS_PER_HIST=4.)
- Pass-through: m_axis_tready=1, push 12 words 0x00000001..0x0000000C back-to-back.
  - Each word appears 1 cycle later, in order.
  - tlast on words 4, 8, 12; hist_idx 0, 1, 2.
  - frame_done_o pulses once, 1 cycle after word 12; level_o never exceeds 1.
- Back-pressure: m_axis_tready=0, push continuously.
  - s_axis_tready falls when level reaches 6.
  - Push 2 more words: level=8, overflow_o=0.
  - Push a 9th word: overflow_o=1, word dropped.
  - Drain shows words 1..8 intact.
- Full with simultaneous push/pop: level=8, tready=1, tvalid=1 for 5 cycles → level stays 8, no overflow, output order preserved.
- Stall stability: tvalid=1, tready toggled 1/0 every cycle over 4 words → tdata and tlast are held during 0-cycles; tlast occurs only on the 4th word.
- clear_i mid-frame: after 6 pops (hist_idx=1, word_cnt=2, level=3), assert clear_i for 1 cycle.
  - Next cycle: level=0, m_axis_tvalid=0, overflow_o=0, s_axis_tready=1.
  - The next pushed word is reported with hist_idx=0.
- Async reset mid-operation: drop rst_n between edges with level=5 → all outputs reach reset values immediately, without a clock edge.
  - With MRELBP_OUT_TUSER_EN: m_axis_tuser = 3'b100 on the first word after release.
